// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous video SRAM between the VGA scanout
// reader (port V, high priority, read-only) and the text/font renderer
// (port R, read/write). One access at a time: IDLE (arbitrate) -> ACCESS
// (strobes active) -> RECOVER (bus turnaround). A streak counter forces an R
// grant after MAX_V_STREAK consecutive V grants taken while R was waiting.
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_V_STREAK  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_req,
    input  logic [ADDR_W-1:0]   v_addr,
    output logic                v_ack,
    output logic                v_rvalid,
    output logic [DATA_W-1:0]   v_rdata,
    input  logic                r_req,
    input  logic                r_we,
    input  logic [ADDR_W-1:0]   r_addr,
    input  logic [DATA_W-1:0]   r_wdata,
    input  logic [DATA_W/8-1:0] r_be,
    output logic                r_ack,
    output logic                r_rvalid,
    output logic [DATA_W-1:0]   r_rdata,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [DATA_W/8-1:0] sram_be_n,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int STK_W = $clog2(MAX_V_STREAK + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_V_STREAK);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [STK_W-1:0] streak;
    logic             op_v;
    logic             op_we;
    logic [BE_W-1:0]  op_be;
    logic             force_r;
    logic             grant_v;
    logic             grant_r;
    logic             in_access;
    logic             last_access;

    // Arbitration in IDLE: V has priority unless R has been starved too long.
    // Grants are gated by rst so no ack can appear while reset is held.
    always_comb begin
        force_r = r_req && (streak == STK_MAX);
        grant_v = (state == IDLE) && v_req && !force_r && rst;
        grant_r = (state == IDLE) && r_req && (!v_req || force_r) && rst;
    end

    assign v_ack = grant_v;
    assign r_ack = grant_r;

    // Access sequencer: IDLE -> ACCESS for ACCESS_CYCLES cycles -> RECOVER -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_v || grant_r) begin
                        state <= ACCESS;
                        cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) state <= RECOVER;
                    else                 cnt   <= cnt + CNT_W'(1);
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the winner's command at the end of the grant cycle; it stays
    // stable on the SRAM pins for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            op_v       <= 1'b0;
            op_we      <= 1'b0;
            op_be      <= '0;
        end else if (grant_v) begin
            sram_addr <= v_addr;
            op_v      <= 1'b1;
            op_we     <= 1'b0;
            op_be     <= '1;
        end else if (grant_r) begin
            sram_addr  <= r_addr;
            sram_wdata <= r_wdata;
            op_v       <= 1'b0;
            op_we      <= r_we;
            op_be      <= r_be;
        end
    end

    // Starvation counter: counts V grants taken while R waits, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (!r_req || grant_r) begin
            streak <= '0;
        end else if (grant_v && (streak != STK_MAX)) begin
            streak <= streak + STK_W'(1);
        end
    end

    assign in_access   = (state == ACCESS);
    assign last_access = in_access && (cnt == LAST_CNT);

    // Capture read data on the last ACCESS cycle; rvalid pulses in RECOVER
    // and each port's rdata holds until that port's next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_rvalid <= 1'b0;
            r_rvalid <= 1'b0;
            v_rdata  <= '0;
            r_rdata  <= '0;
        end else begin
            v_rvalid <= 1'b0;
            r_rvalid <= 1'b0;
            if (last_access && !op_we) begin
                if (op_v) begin
                    v_rvalid <= 1'b1;
                    v_rdata  <= sram_rdata;
                end else begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= sram_rdata;
                end
            end
        end
    end

    // Strobes decode from registered state only, so reset drops them at once.
    // we_n releases one cycle early to give the SRAM data hold time.
    always_comb begin
        sram_ce_n  = !in_access;
        sram_oe_n  = !(in_access && !op_we);
        sram_we_n  = !(in_access && op_we && !last_access);
        sram_dq_oe = in_access && op_we;
        sram_be_n  = in_access ? ~op_be : '1;
    end

    a_v_hold: assert property (@(posedge clk) disable iff (!rst) (v_req && !v_ack) |=> v_req);
    a_r_hold: assert property (@(posedge clk) disable iff (!rst) (r_req && !r_ack) |=> r_req);
    a_one_ack: assert property (@(posedge clk) disable iff (!rst) !(v_ack && r_ack));

endmodule
